// File: rtl/text_fetch.sv
// Double-buffered text-row fetcher: fills a back line buffer from memory ahead of each
// text row and swaps it to the renderer at the row start. Define TEXT_FETCH_TIMEOUT_EN for a read watchdog.
module text_fetch #(
   parameter logic [9:0]  FETCH_H = 10'd600,
   parameter logic [8:0]  V_TOP   = 9'd16,
   parameter int unsigned NCOL    = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_pix,
   input  logic [9:0]  H,
   input  logic [8:0]  V,
   input  logic        page2,
   output logic [22:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [7:0]  mem_data,
   input  logic [5:0]  rd_col,
   output logic [7:0]  rd_data,
   output logic        line_miss,
   output logic        fetch_err
);
   localparam logic [5:0] LastCol = 6'(NCOL - 1);

   typedef enum logic [1:0] {StIdle, StReq, StGap, StDone} state_e;

   state_e      state_q, state_d;
   logic [5:0]  col_q, col_d;
   logic [22:0] mem_addr_q, mem_addr_d;
   logic        front_sel_q, front_sel_d;
   logic        line_miss_q, line_miss_d;
   logic        fetch_err_q, fetch_err_d;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic [7:0]  buf_q [2][NCOL];

   logic [9:0]  v_ext, v_top_ext;
   logic [6:0]  row_full;
   logic [4:0]  row;
   logic [9:0]  row_base;
   logic [22:0] page_base;
   logic        trigger, swap, timeout;

   always_comb begin
      v_ext     = {1'b0, V};
      v_top_ext = {1'b0, V_TOP};
      row_full  = 7'((v_ext + 10'd1 - v_top_ext) >> 3);
      row       = row_full[4:0];
      // Rows interleave in 128-byte groups of eight, with thirds offset by 40 bytes.
      row_base  = {row[2:0], 7'b0} + ({8'b0, row[4:3]} * 10'd40);
      page_base = page2 ? 23'h800 : 23'h400;
      trigger   = ce_pix && (H == FETCH_H) && (row_full <= 7'd23) &&
                  ((V == V_TOP - 9'd1) ||
                   ((v_ext >= v_top_ext) && (v_ext < v_top_ext + 10'd184) && (V[2:0] == 3'd7)));
      swap      = ce_pix && (H == 10'd0) && (v_ext >= v_top_ext) &&
                  (v_ext < v_top_ext + 10'd192) && (V[2:0] == 3'd0);
   end

`ifdef TEXT_FETCH_TIMEOUT_EN
   logic [7:0] wdog_q, wdog_d;

   always_comb begin
      timeout = (state_q == StReq) && !mem_ack && (wdog_q == 8'd254);
      wdog_d  = ((state_q == StReq) && !mem_ack && !timeout) ? wdog_q + 8'd1 : 8'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) wdog_q <= '0;
      else       wdog_q <= wdog_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      mem_addr_d  = mem_addr_q;
      front_sel_d = front_sel_q;
      line_miss_d = 1'b0;
      fetch_err_d = 1'b0;
      wr_en       = 1'b0;
      wr_data     = mem_data;
      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               state_d    = StReq;
               col_d      = '0;
               mem_addr_d = page_base + {13'b0, row_base};
            end
         end
         StReq: begin
            if (mem_ack) begin
               wr_en   = 1'b1;
               state_d = StGap;
            end else if (timeout) begin
               wr_en       = 1'b1;
               wr_data     = 8'hA0;
               fetch_err_d = 1'b1;
               state_d     = StGap;
            end
         end
         StGap: begin
            if (col_q < LastCol) begin
               col_d      = col_q + 6'd1;
               mem_addr_d = mem_addr_q + 23'd1;
               state_d    = StReq;
            end else begin
               state_d = StDone;
            end
         end
         StDone: ;
         default: state_d = StIdle;
      endcase
      // An unfinished fetch at the row start is abandoned; the old front stays visible.
      if (swap) begin
         if (state_q == StDone) front_sel_d = ~front_sel_q;
         else                   line_miss_d = 1'b1;
         state_d = StIdle;
         wr_en   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         col_q       <= '0;
         mem_addr_q  <= '0;
         front_sel_q <= 1'b0;
         line_miss_q <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         mem_addr_q  <= mem_addr_d;
         front_sel_q <= front_sel_d;
         line_miss_q <= line_miss_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_en) buf_q[~front_sel_q][col_q] <= wr_data;
   end

   assign mem_req   = (state_q == StReq);
   assign mem_addr  = mem_addr_q;
   assign line_miss = line_miss_q;
   assign fetch_err = fetch_err_q;
   assign rd_data   = (rd_col <= LastCol) ? buf_q[front_sel_q][rd_col] : 8'h00;

endmodule

// File: tb/tb_text_fetch.sv
// Bench for text_fetch: table of trigger vectors, randomized rows against an address/buffer
// model, and hand sequences for miss, reset, spurious ack and (with the macro) timeout.
`timescale 1ns/1ps
module tb_text_fetch;
   localparam logic [9:0] FETCH_H = 10'd600;
`ifdef TEXT_FETCH_TIMEOUT_EN
   localparam int STALL = 50;
`else
   localparam int STALL = 300;
`endif

   logic        clk = 1'b0;
   logic        reset, ce_pix, page2, mem_req, mem_ack, line_miss, fetch_err;
   logic [9:0]  H;
   logic [8:0]  V;
   logic [22:0] mem_addr;
   logic [7:0]  mem_data, rd_data;
   logic [5:0]  rd_col;

   always #100 clk = ~clk;

   text_fetch #(.FETCH_H(FETCH_H), .V_TOP(9'd16), .NCOL(40)) dut (
      .clk(clk), .reset(reset), .ce_pix(ce_pix), .H(H), .V(V), .page2(page2),
      .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
      .rd_col(rd_col), .rd_data(rd_data), .line_miss(line_miss), .fetch_err(fetch_err)
   );

   typedef struct {
      logic        ce;
      logic [9:0]  h;
      logic [8:0]  v;
      logic        p2;
      logic        exp_fetch;
      logic [22:0] first;
      logic [22:0] last;
   } vec_t;

   int          checks = 0, errors = 0;
   logic [7:0]  mem [4096];
   logic [7:0]  model_front [40];
   logic [7:0]  model_back [40];
   logic [22:0] acc_addr [$];
   int          req_cnt = 0, cur_delay = 2, no_ack_addr = -1;
   bit          ack_en = 1'b1, rand_delay = 1'b0, spurious = 1'b0, err_seen = 1'b0;
   bit          prev_ack_taken = 1'b0;
   logic        prev_req = 1'b0;
   logic [22:0] prev_addr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [22:0] model_addr(input logic p2, input int r, input int c);
      return 23'((p2 ? 2048 : 1024) + (r % 8) * 128 + (r / 8) * 40 + c);
   endfunction

   // One clock; sample #1 after the edge, check protocol, then act as the memory slave.
   task automatic tick();
      @(posedge clk);
      #1;
      if (fetch_err === 1'b1) err_seen = 1'b1;
      if (prev_req === 1'b1 && mem_req === 1'b1) check("addr_stable", mem_addr, prev_addr);
      if (prev_ack_taken) check("req_drop_after_ack", mem_req, 0);
      prev_req = mem_req;
      prev_addr = mem_addr;
      prev_ack_taken = 1'b0;
      mem_ack = 1'b0;
      mem_data = 8'h00;
      if (mem_req === 1'b1) begin
         req_cnt++;
         if (req_cnt == 1) cur_delay = rand_delay ? int'($urandom_range(4, 1)) : 2;
         if (ack_en && int'(mem_addr) != no_ack_addr && req_cnt >= cur_delay) begin
            mem_ack = 1'b1;
            mem_data = mem[mem_addr[11:0]];
            prev_ack_taken = 1'b1;
            acc_addr.push_back(mem_addr);
         end
      end else begin
         req_cnt = 0;
         if (spurious) begin
            mem_ack = 1'b1;
            mem_data = 8'hEE;
         end
      end
   endtask

   task automatic start_fetch(input logic ce, input logic [9:0] h, input logic [8:0] v,
                              input logic p2);
      acc_addr.delete();
      ce_pix = ce; H = h; V = v; page2 = p2;
      tick();
      ce_pix = 1'b1; H = 10'd100; page2 = ~p2;
   endtask

   task automatic finish_fetch(input logic p2, input int r, input string tag);
      int n = 0;
      int bad = 0;
      logic [22:0] a;
      while (acc_addr.size() < 40 && n < 3000) begin
         tick();
         n++;
      end
      check({tag, "_writes"}, acc_addr.size(), 40);
      repeat (3) tick();
      check({tag, "_req_idle"}, mem_req, 0);
      for (int c = 0; c < 40; c++) begin
         a = model_addr(p2, r, c);
         if (c >= acc_addr.size() || acc_addr[c] !== a) bad++;
         model_back[c] = mem[a[11:0]];
      end
      check({tag, "_addr_seq"}, bad, 0);
   endtask

   task automatic do_swap(input logic [8:0] v);
      ce_pix = 1'b1; H = 10'd0; V = v;
      tick();
      H = 10'd100;
   endtask

   task automatic check_front(input string tag);
      int bad = 0;
      for (int c = 0; c < 40; c++) begin
         rd_col = 6'(c);
         #1;
         if (rd_data !== model_front[c]) bad++;
      end
      check({tag, "_mismatches"}, bad, 0);
      rd_col = 6'd40; #1;
      check({tag, "_col40"}, rd_data, 0);
      rd_col = 6'd63; #1;
      check({tag, "_col63"}, rd_data, 0);
      rd_col = 6'd0;
   endtask

   vec_t vecs [12];
   int   r, n;
   logic p2;
`ifdef TEXT_FETCH_TIMEOUT_EN
   int   cnt;
`endif

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      vecs[0]  = '{1'b1, 10'd600, 9'd15,  1'b0, 1'b1, 23'h400, 23'h427};
      vecs[1]  = '{1'b1, 10'd600, 9'd87,  1'b1, 1'b1, 23'h8A8, 23'h8CF};
      vecs[2]  = '{1'b1, 10'd600, 9'd23,  1'b0, 1'b1, 23'h480, 23'h4A7};
      vecs[3]  = '{1'b1, 10'd600, 9'd79,  1'b0, 1'b1, 23'h428, 23'h44F};
      vecs[4]  = '{1'b1, 10'd600, 9'd135, 1'b0, 1'b1, 23'h7A8, 23'h7CF};
      vecs[5]  = '{1'b1, 10'd600, 9'd199, 1'b1, 1'b1, 23'hBD0, 23'hBF7};
      vecs[6]  = '{1'b0, 10'd600, 9'd15,  1'b0, 1'b0, 23'h0,   23'h0};
      vecs[7]  = '{1'b1, 10'd599, 9'd15,  1'b0, 1'b0, 23'h0,   23'h0};
      vecs[8]  = '{1'b1, 10'd600, 9'd207, 1'b0, 1'b0, 23'h0,   23'h0};
      vecs[9]  = '{1'b1, 10'd600, 9'd16,  1'b0, 1'b0, 23'h0,   23'h0};
      vecs[10] = '{1'b1, 10'd600, 9'd14,  1'b0, 1'b0, 23'h0,   23'h0};
      vecs[11] = '{1'b1, 10'd600, 9'd7,   1'b0, 1'b0, 23'h0,   23'h0};

      reset = 1'b1; ce_pix = 1'b0; H = 10'd100; V = 9'd0; page2 = 1'b0;
      mem_ack = 1'b0; mem_data = 8'h00; rd_col = 6'd0;
      repeat (3) tick();
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_miss", line_miss, 0);
      check("rst_err", fetch_err, 0);

      // Reset wins over a coincident trigger.
      ce_pix = 1'b1; H = FETCH_H; V = 9'd15;
      tick();
      reset = 1'b0; H = 10'd100;
      repeat (3) tick();
      check("rst_prio_trigger", mem_req, 0);

      for (int i = 0; i < 12; i++) begin
         start_fetch(vecs[i].ce, vecs[i].h, vecs[i].v, vecs[i].p2);
         if (!vecs[i].exp_fetch) begin
            repeat (3) tick();
            check($sformatf("vec%0d_no_trigger", i), mem_req, 0);
         end else begin
            r = (int'(vecs[i].v) + 1 - 16) / 8;
            finish_fetch(vecs[i].p2, r, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_first", i), acc_addr.size() > 0 ? acc_addr[0] : 23'h0,
                  vecs[i].first);
            check($sformatf("vec%0d_last", i), acc_addr.size() > 39 ? acc_addr[39] : 23'h0,
                  vecs[i].last);
            do_swap(9'd16);
            check($sformatf("vec%0d_no_miss", i), line_miss, 0);
            model_front = model_back;
            check_front($sformatf("vec%0d_front", i));
            if (i == 0) begin
               rd_col = 6'd5; #1;
               check("row0_rd5", rd_data, mem[12'h405]);
               rd_col = 6'd0;
            end
         end
      end

      // Acks while mem_req is low must not write or advance.
      start_fetch(1'b1, FETCH_H, 9'd55, 1'b0);
      finish_fetch(1'b0, 5, "spur");
      spurious = 1'b1;
      repeat (6) tick();
      spurious = 1'b0;
      check("spur_addr_hold", mem_addr, model_addr(1'b0, 5, 39));
      check("spur_req_low", mem_req, 0);
      do_swap(9'd24);
      model_front = model_back;
      check_front("spur_front");

      rand_delay = 1'b1;
      for (int it = 0; it < 6; it++) begin
         r = int'($urandom_range(23));
         p2 = 1'($urandom_range(1));
         spurious = it[0];
         start_fetch(1'b1, FETCH_H, 9'(15 + 8 * r), p2);
         finish_fetch(p2, r, $sformatf("rand%0d", it));
         spurious = 1'b0;
         do_swap(9'(16 + 8 * int'($urandom_range(23))));
         check($sformatf("rand%0d_no_miss", it), line_miss, 0);
         model_front = model_back;
         check_front($sformatf("rand%0d_front", it));
      end
      rand_delay = 1'b0;

      // Stalled fetch reaching the row start.
      start_fetch(1'b1, FETCH_H, 9'd39, 1'b0);
      n = 0;
      while (acc_addr.size() < 10 && n < 500) begin tick(); n++; end
      check("miss_progress", acc_addr.size(), 10);
      ack_en = 1'b0;
      repeat (STALL) tick();
      check("stall_req_held", mem_req, 1);
`ifndef TEXT_FETCH_TIMEOUT_EN
      check("no_fetch_err", err_seen, 0);
`endif
      do_swap(9'd40);
      check("miss_pulse", line_miss, 1);
      check("miss_req_drop", mem_req, 0);
      tick();
      check("miss_pulse_end", line_miss, 0);
      ack_en = 1'b1;
      repeat (5) tick();
      check("miss_stays_idle", mem_req, 0);
      check_front("miss_front");

      // Reset in the middle of column 17.
      start_fetch(1'b1, FETCH_H, 9'd31, 1'b0);
      n = 0;
      while (!(mem_req === 1'b1 && mem_addr === model_addr(1'b0, 2, 17)) && n < 500) begin
         tick();
         n++;
      end
      check("col17_reached", acc_addr.size(), 17);
      reset = 1'b1;
      tick();
      check("midrst_req", mem_req, 0);
      check("midrst_addr", mem_addr, 0);
      reset = 1'b0;
      tick();
      check("midrst_idle", mem_req, 0);
      start_fetch(1'b1, FETCH_H, 9'd31, 1'b0);
      finish_fetch(1'b0, 2, "postrst");
      check("postrst_col0", acc_addr.size() > 0 ? acc_addr[0] : 23'h0, 23'h500);
      do_swap(9'd32);
      check("postrst_no_miss", line_miss, 0);
      model_front = model_back;
      check_front("postrst_front");

`ifdef TEXT_FETCH_TIMEOUT_EN
      start_fetch(1'b1, FETCH_H, 9'd15, 1'b0);
      no_ack_addr = 'h403;
      n = 0;
      while (!(mem_req === 1'b1 && mem_addr === 23'h403) && n < 500) begin tick(); n++; end
      cnt = 1;
      while (mem_req === 1'b1 && cnt < 400) begin
         tick();
         if (mem_req === 1'b1) cnt++;
      end
      check("timeout_err", fetch_err, 1);
      check("timeout_cycles", cnt, 255);
      acc_addr.push_back(23'h403);
      no_ack_addr = -1;
      n = 0;
      while (mem_req !== 1'b1 && n < 10) begin tick(); n++; end
      check("timeout_next_col", mem_addr, 23'h404);
      finish_fetch(1'b0, 0, "timeout");
      model_back[3] = 8'hA0;
      do_swap(9'd16);
      model_front = model_back;
      check_front("timeout_front");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
